// File: rtl/dsp_mac_pkg.sv
// ----------------------------------------------------------------------------
// dsp_mac_pkg
//   Shared definitions for the DSP-slice MAC sequencer:
//   - slice OPMODE encodings used by the sequencer
//   - ALU mode constant (plain add)
//   - controller state enum
//   - pipeline tag carried alongside each operand pair
//   - helper that turns a tag into the OPMODE the slice should see
// ----------------------------------------------------------------------------
package dsp_mac_pkg;

    // Z mux selects 0, X/Y select M: P = M (first term, fresh accumulation)
    localparam logic [6:0] OPM_FIRST = 7'b0000101;
    // Z mux selects P, X/Y select M: P = P + M
    localparam logic [6:0] OPM_ACC   = 7'b0100101;
    // Z mux selects P, X/Y select 0: P holds
    localparam logic [6:0] OPM_HOLD  = 7'b0100000;
    // Z mux selects C, X/Y select M: P = C + M (first term with bias)
    localparam logic [6:0] OPM_BIAS  = 7'b0110101;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

    // Bubbles hold P, the first term restarts the sum, later terms accumulate.
    function automatic logic [6:0] tag_opmode(input tag_t t, input logic [6:0] first_opm);
        logic [6:0] opm;
        casez (t)
            3'b11?:  opm = first_opm;
            3'b10?:  opm = OPM_ACC;
            default: opm = OPM_HOLD;
        endcase
        return opm;
    endfunction

endpackage

// File: rtl/dsp_mac_tagpipe.sv
// ----------------------------------------------------------------------------
// dsp_mac_tagpipe
//   Shift register of {vld, first, last} tags that mirrors the DSP slice
//   pipeline, one stage per clock edge.
//
//   Ports:
//     clk      in   clock
//     rst      in   synchronous active-low reset, clears every stage
//     tag_in   in   tag of the operand pair loaded this edge (vld=0 for bubble)
//     tag_tap  out  tag at stage TAP (drives the slice OPMODE)
//     retire   out  last stage holds a valid, last term (P is final)
//     any_vld  out  some stage still carries a valid term
// ----------------------------------------------------------------------------
module dsp_mac_tagpipe
    import dsp_mac_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAP   = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_tap,
    output logic retire,
    output logic any_vld
);

    localparam tag_t RETIRE_MASK = '{vld: 1'b1, first: 1'b0, last: 1'b1};

    tag_t [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], tag_in};
        end
    end

    assign tag_tap = stages[TAP];
    assign retire  = ((stages[DEPTH-1] & RETIRE_MASK) == RETIRE_MASK);

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_vld = any_vld | stages[i].vld;
        end
    end

endmodule

// File: rtl/dsp_mac_seq.sv
// ----------------------------------------------------------------------------
// dsp_mac_seq
//   Drives a DSP slice (AREG=BREG=MREG=PREG=1, registered OPMODE/ALUMODE,
//   direct A/B inputs) as a streaming multiply-accumulate engine computing
//   signed dot products of programmable length.
//
//   Optional feature macro: DSP_MAC_BIAS_EN
//     When defined, adds a 48-bit signed 'bias' input sampled with cfg_len;
//     the first term then computes P = C + M with C = bias.
//
//   Ports:
//     clk, rst          clock, synchronous active-low reset
//     cfg_len           term count (0 treated as 1), sampled on first handshake
//     in_valid/in_ready operand-pair stream handshake
//     in_a, in_b        signed 25-bit / 18-bit operands
//     dsp_a, dsp_b      registered operands to slice A/B (A sign-extended)
//     dsp_c             slice C (bias when enabled, else 0)
//     dsp_op_mode       slice OPMODE, from the tag pipe
//     dsp_alu_mode      constant add
//     dsp_inmode        constant 0
//     dsp_carryinsel    constant 0
//     dsp_p             slice P output
//     res_valid/ready   result stream handshake
//     res_data          captured signed dot product
//     busy              controller or slice pipeline still active
// ----------------------------------------------------------------------------
module dsp_mac_seq
    import dsp_mac_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3,
    parameter int OPM_TAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_a,
    input  logic [17:0]      in_b,
`ifdef DSP_MAC_BIAS_EN
    input  logic [47:0]      bias,
`endif
    output logic [29:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [47:0]      dsp_c,
    output logic [6:0]       dsp_op_mode,
    output logic [3:0]       dsp_alu_mode,
    output logic [4:0]       dsp_inmode,
    output logic [1:0]       dsp_carryinsel,
    input  logic [47:0]      dsp_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             busy
);

    state_t           state, state_next;
    logic [LEN_W-1:0] len_q, count_q, len_eff;
    logic             fire, is_first, is_last, capture, pipe_busy;
    tag_t             tag_new, tag_tap;

    assign fire     = in_valid && in_ready;
    assign is_first = (state == IDLE);
    assign len_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

    // The first term compares against the freshly sampled length; later
    // terms compare the post-increment count against the stored length.
    assign is_last  = is_first ? (len_eff == LEN_W'(1))
                               : ((count_q + LEN_W'(1)) == len_q);

    assign tag_new = '{vld: fire, first: fire && is_first, last: fire && is_last};

    dsp_mac_tagpipe #(
        .DEPTH (PIPE_LAT + 1),
        .TAP   (OPM_TAP)
    ) u_tagpipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_new),
        .tag_tap (tag_tap),
        .retire  (capture),
        .any_vld (pipe_busy)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fire) state_next = is_last ? DRAIN : ACCUM;
            ACCUM:   if (fire && is_last) state_next = DRAIN;
            DRAIN:   if (capture) state_next = HOLD;
            HOLD:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; in_ready is gated by rst so nothing is accepted in reset
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE, ACCUM: in_ready  = rst;
            HOLD:        res_valid = 1'b1;
            default:     ;
        endcase
    end

    // Operand registers, term counter and result capture. Bubbles load zeros.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dsp_a    <= '0;
            dsp_b    <= '0;
            len_q    <= '0;
            count_q  <= '0;
            res_data <= '0;
        end else begin
            dsp_a <= fire ? {{5{in_a[24]}}, in_a} : '0;
            dsp_b <= fire ? in_b : '0;
            if (fire) begin
                if (is_first) begin
                    len_q   <= len_eff;
                    count_q <= LEN_W'(1);
                end else begin
                    count_q <= count_q + LEN_W'(1);
                end
            end
            if (capture) begin
                res_data <= dsp_p;
            end
        end
    end

`ifdef DSP_MAC_BIAS_EN
    localparam logic [6:0] FIRST_OPM = OPM_BIAS;

    // C carries the bias from the first handshake until P has been captured.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dsp_c <= '0;
        end else if (fire && is_first) begin
            dsp_c <= bias;
        end else if (capture) begin
            dsp_c <= '0;
        end
    end
`else
    localparam logic [6:0] FIRST_OPM = OPM_FIRST;

    assign dsp_c = '0;
`endif

    assign dsp_op_mode    = tag_opmode(tag_tap, FIRST_OPM);
    assign dsp_alu_mode   = ALU_ADD;
    assign dsp_inmode     = '0;
    assign dsp_carryinsel = '0;
    assign busy           = (state != IDLE) || pipe_busy;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// ----------------------------------------------------------------------------
// tb_dsp_mac_seq
//   Bench for dsp_mac_seq with a behavioural DSP slice model on dsp_p.
//   Table-driven dot products, hand-written corner sequences, then random
//   dot products checked against a plain-arithmetic reference.
// ----------------------------------------------------------------------------
module tb_dsp_mac_seq;

    localparam int         LEN_W    = 8;
    localparam int         PIPE_LAT = 3;
    localparam logic [6:0] OPM_HOLD_EXP = 7'b0100000;

    logic             clk = 1'b0;
    logic             rst;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_a;
    logic [17:0]      in_b;
`ifdef DSP_MAC_BIAS_EN
    logic [47:0]      bias;
`endif
    logic [29:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [47:0]      dsp_c;
    logic [6:0]       dsp_op_mode;
    logic [3:0]       dsp_alu_mode;
    logic [4:0]       dsp_inmode;
    logic [1:0]       dsp_carryinsel;
    logic [47:0]      dsp_p;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_data;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic signed [24:0] cur_a[$];
    logic signed [17:0] cur_b[$];
    longint             cur_bias = 0;

    always #5 clk = ~clk;

    dsp_mac_seq #(
        .LEN_W    (LEN_W),
        .PIPE_LAT (PIPE_LAT),
        .OPM_TAP  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_len        (cfg_len),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
`ifdef DSP_MAC_BIAS_EN
        .bias           (bias),
`endif
        .dsp_a          (dsp_a),
        .dsp_b          (dsp_b),
        .dsp_c          (dsp_c),
        .dsp_op_mode    (dsp_op_mode),
        .dsp_alu_mode   (dsp_alu_mode),
        .dsp_inmode     (dsp_inmode),
        .dsp_carryinsel (dsp_carryinsel),
        .dsp_p          (dsp_p),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .busy           (busy)
    );

    // DSP slice model: A/B register, M register with registered OPMODE and C,
    // then P = Z + XY where Z is 0/P/C and XY is 0/M.
    logic [29:0]        sl_a;
    logic [17:0]        sl_b;
    logic signed [47:0] sl_m, sl_c, sl_p, sl_z, sl_xy;
    logic [6:0]         sl_opm;

    always_comb begin
        case (sl_opm[6:4])
            3'b010:  sl_z = sl_p;
            3'b011:  sl_z = sl_c;
            default: sl_z = '0;
        endcase
        sl_xy = (sl_opm[3:0] == 4'b0101) ? sl_m : '0;
    end

    always @(posedge clk) begin
        sl_a   <= dsp_a;
        sl_b   <= dsp_b;
        sl_m   <= 48'($signed(sl_a) * $signed(sl_b));
        sl_opm <= dsp_op_mode;
        sl_c   <= dsp_c;
        sl_p   <= sl_z + sl_xy;
    end

    assign dsp_p = sl_p;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] sx48(input logic [47:0] v);
        return {{16{v[47]}}, v};
    endfunction

    // Reference: bias plus sum of products, wrapped to 48-bit two's complement.
    function automatic longint refDot(input int n);
        longint acc;
        acc = cur_bias;
        for (int i = 0; i < n; i++) begin
            acc += longint'(cur_a[i]) * longint'(cur_b[i]);
        end
        return longint'(sx48(acc[47:0]));
    endfunction

    task automatic checkOutput(input string what, input logic [63:0] actual,
                               input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", what, actual, required);
        end
    endtask

    // Drives the queued terms; cfg_len and bias are scrambled after each
    // handshake since only the first handshake may sample them.
    task automatic applyStimulus(input int len_cfg, input int gap, output bit ok);
        ok      = 1'b1;
        cfg_len = LEN_W'(len_cfg);
`ifdef DSP_MAC_BIAS_EN
        bias    = cur_bias[47:0];
`endif
        for (int i = 0; i < cur_a.size(); i++) begin
            int waited;
            waited   = 0;
            in_valid = 1'b1;
            in_a     = cur_a[i];
            in_b     = cur_b[i];
            @(negedge clk);
            while (!in_ready && waited < 64) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("[TB] FAIL handshake timeout term %0d: in_ready=0 required=1", i);
                in_valid = 1'b0;
                ok = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_a     = 25'($urandom);
            in_b     = 18'($urandom);
            cfg_len  = LEN_W'($urandom);
`ifdef DSP_MAC_BIAS_EN
            bias     = 48'({$urandom, $urandom});
`endif
            if (i != cur_a.size() - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    // Called right after the last-term handshake edge.
    task automatic expectResult(input string name, input longint expv, input int rr_wait);
        for (int e = 0; e < PIPE_LAT + 1; e++) begin
            @(negedge clk);
            checkOutput($sformatf("%s drain%0d valid,ready", name, e),
                        {62'b0, res_valid, in_ready}, 64'd0);
        end
        @(negedge clk);
        checkOutput({name, " res_valid latency"}, {63'b0, res_valid}, 64'd1);
        checkOutput({name, " res_data"}, sx48(res_data), 64'(expv));
        for (int w = 0; w < rr_wait; w++) begin
            @(negedge clk);
            checkOutput($sformatf("%s hold%0d valid,ready", name, w),
                        {62'b0, res_valid, in_ready}, 64'd2);
            checkOutput($sformatf("%s hold%0d data", name, w), sx48(res_data), 64'(expv));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({name, " release valid,ready,busy"},
                    {61'b0, res_valid, in_ready, busy}, 64'd2);
        res_ready = 1'b0;
    endtask

    typedef struct {
        int     len_cfg;
        int     nterms;
        int     a[4];
        int     b[4];
        int     gap;
        int     rr_wait;
        longint expv;
    } vec_t;

    vec_t vecs[6];
    bit   ok;
    int   n, lc, seen;
    longint expv;
    logic [47:0] tmp48;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        cfg_len   = '0;
        res_ready = 1'b0;
`ifdef DSP_MAC_BIAS_EN
        bias      = '0;
`endif

        vecs[0] = '{len_cfg: 4, nterms: 4, a: '{1, 2, 3, 4}, b: '{5, 6, 7, 8},
                    gap: 0, rr_wait: 0, expv: 70};
        vecs[1] = '{len_cfg: 2, nterms: 2, a: '{-3, 16777215, 0, 0}, b: '{7, -2, 0, 0},
                    gap: 0, rr_wait: 1, expv: -33554451};
        vecs[2] = '{len_cfg: 3, nterms: 3, a: '{1, 2, 3, 0}, b: '{1, 2, 3, 0},
                    gap: 2, rr_wait: 5, expv: 14};
        vecs[3] = '{len_cfg: 0, nterms: 1, a: '{9, 0, 0, 0}, b: '{9, 0, 0, 0},
                    gap: 0, rr_wait: 0, expv: 81};
        vecs[4] = '{len_cfg: 1, nterms: 1, a: '{9, 0, 0, 0}, b: '{9, 0, 0, 0},
                    gap: 0, rr_wait: 2, expv: 81};
        vecs[5] = '{len_cfg: 4, nterms: 4, a: '{-16777216, -16777216, -16777216, -16777216},
                    b: '{-131072, -131072, -131072, -131072},
                    gap: 1, rr_wait: 0, expv: 64'sd8796093022208};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", {63'b0, in_ready}, 64'd0);
        checkOutput("reset res_valid", {63'b0, res_valid}, 64'd0);
        checkOutput("reset res_data", {16'b0, res_data}, 64'd0);
        checkOutput("reset dsp_a", {34'b0, dsp_a}, 64'd0);
        checkOutput("reset dsp_b", {46'b0, dsp_b}, 64'd0);
        checkOutput("reset dsp_c", {16'b0, dsp_c}, 64'd0);
        checkOutput("reset op_mode", {57'b0, dsp_op_mode}, {57'b0, OPM_HOLD_EXP});
        checkOutput("const alu,inmode,carryinsel",
                    {53'b0, dsp_alu_mode, dsp_inmode, dsp_carryinsel}, 64'd0);
        checkOutput("reset busy", {63'b0, busy}, 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("idle in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            cur_a.delete();
            cur_b.delete();
            for (int i = 0; i < vecs[v].nterms; i++) begin
                cur_a.push_back(25'(vecs[v].a[i]));
                cur_b.push_back(18'(vecs[v].b[i]));
            end
            applyStimulus(vecs[v].len_cfg, vecs[v].gap, ok);
            if (ok) expectResult($sformatf("vec%0d", v), vecs[v].expv, vecs[v].rr_wait);
        end

        // Maximum length with the largest product: 255 * 2^41 wraps to -2^41.
        cur_a.delete();
        cur_b.delete();
        for (int i = 0; i < 255; i++) begin
            cur_a.push_back(-25'sd16777216);
            cur_b.push_back(-18'sd131072);
        end
        applyStimulus(255, 0, ok);
        if (ok) expectResult("maxlen wrap", -64'sd2199023255552, 1);

        // Reset after 2 of 4 terms: nothing may come out.
        cur_a.delete();
        cur_b.delete();
        cur_a.push_back(25'sd1);  cur_b.push_back(18'sd1);
        cur_a.push_back(25'sd2);  cur_b.push_back(18'sd1);
        applyStimulus(4, 0, ok);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("midreset busy,valid", {62'b0, busy, res_valid}, 64'd0);
        checkOutput("midreset op_mode", {57'b0, dsp_op_mode}, {57'b0, OPM_HOLD_EXP});
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        checkOutput("midreset no result", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        cur_a.delete();
        cur_b.delete();
        cur_a.push_back(25'sd2);  cur_b.push_back(18'sd3);
        applyStimulus(1, 0, ok);
        if (ok) expectResult("after reset", 6, 0);

`ifdef DSP_MAC_BIAS_EN
        cur_bias = 100;
        cur_a.delete();
        cur_b.delete();
        cur_a.push_back(25'sd2);  cur_b.push_back(18'sd4);
        cur_a.push_back(25'sd3);  cur_b.push_back(18'sd5);
        applyStimulus(2, 0, ok);
        if (ok) expectResult("bias", 123, 1);
`endif

        for (int r = 0; r < 24; r++) begin
            n  = $urandom_range(1, 8);
            lc = (n == 1 && $urandom_range(0, 1) == 1) ? 0 : n;
            cur_a.delete();
            cur_b.delete();
            for (int i = 0; i < n; i++) begin
                cur_a.push_back(25'($urandom));
                cur_b.push_back(18'($urandom));
            end
`ifdef DSP_MAC_BIAS_EN
            tmp48    = 48'({$urandom, $urandom});
            cur_bias = longint'(sx48(tmp48));
`else
            cur_bias = 0;
`endif
            expv = refDot(n);
            applyStimulus(lc, $urandom_range(0, 2), ok);
            if (ok) expectResult($sformatf("rand%0d", r), expv, $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
